// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One transaction is in flight at a time: IDLE (accept) -> ACCESS (drive RAM) -> RESP (complete).
module ram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m0_we,
   input  logic              m1_we,
   output logic              m0_ready,
   output logic              m1_ready,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                sel;
   logic [DATA_W-1:0]   resp_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Ready is gated by reset so nothing is acknowledged while reset is held.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      sel      = 1'b0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (reset && (m0_req || m1_req)) begin
               sel      = (m0_req && m1_req) ? ~last_q : m1_req;
               m0_ready = ~sel;
               m1_ready = sel;
               grant_d  = sel;
               last_d   = sel;
               we_d     = sel ? m1_we    : m0_we;
               addr_d   = sel ? m1_addr  : m0_addr;
               wdata_d  = sel ? m1_wdata : m0_wdata;
               state_d  = ACCESS;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ram_address      = addr_q;
   assign ram_data_in      = wdata_q;
   assign ram_write_enable = (state_q == ACCESS) && we_q;
   assign busy             = (state_q != IDLE);
   assign dbg_state        = state_q;

   assign m0_rvalid = (state_q == RESP) && !grant_q;
   assign m1_rvalid = (state_q == RESP) &&  grant_q;
   assign resp_data = we_q ? '0 : ram_data_out;
   assign m0_rdata  = m0_rvalid ? resp_data : '0;
   assign m1_rdata  = m1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, per-port scoreboards checked on completion pulses.
module tb_ram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          m0_req = 1'b0, m1_req = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_we = 1'b0, m1_we = 1'b0;
   logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic          ram_write_enable;
   logic [DW-1:0] ram_data_out = '0;
   logic          busy;
   logic [1:0]    dbg_state;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_we(m0_we), .m1_we(m1_we),
      .m0_ready(m0_ready), .m1_ready(m1_ready),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: write on the edge, read data registered for the next cycle.
   logic [DW-1:0] mem [16];
   logic [DW-1:0] ref_mem [16];
   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_address[3:0]] <= ram_data_in;
      ram_data_out <= mem[ram_address[3:0]];
   end

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] cyc;
   } txn_t;

   txn_t sb0[$];
   txn_t sb1[$];
   logic acc_log[$];
   logic last_acc = 1'b1;
   int   rv0_cnt = 0, rv1_cnt = 0;
   int   n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: record acceptances, score completions against the reference memory.
   always @(negedge clk) begin
      txn_t e;
      if (!reset) begin
         sb0.delete();
         sb1.delete();
         last_acc = 1'b1;
         check("rst_ready", {m0_ready, m1_ready}, 0);
         check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
         check("rst_rdata", {m0_rdata, m1_rdata}, 0);
         check("rst_we", ram_write_enable, 0);
         check("rst_addr", ram_address, 0);
         check("rst_din", ram_data_in, 0);
         check("rst_busy", busy, 0);
         check("rst_state", dbg_state, 0);
      end else begin
         if (ram_write_enable) check("we_busy", busy, 1);
         if (m0_ready) begin
            if (m1_req) check("rr_m0", last_acc, 1);
            sb0.push_back({m0_we, m0_addr[3:0], m0_wdata, cyc + 32'd2});
            last_acc = 1'b0;
            acc_log.push_back(1'b0);
         end
         if (m1_ready) begin
            if (m0_req) check("rr_m1", last_acc, 0);
            sb1.push_back({m1_we, m1_addr[3:0], m1_wdata, cyc + 32'd2});
            last_acc = 1'b1;
            acc_log.push_back(1'b1);
         end
         if (m0_rvalid) begin
            rv0_cnt++;
            if (sb0.size() == 0) check("m0_unexpected_rvalid", 1, 0);
            else begin
               e = sb0.pop_front();
               check("m0_rdata", m0_rdata, e.we ? 32'd0 : ref_mem[e.addr]);
               check("m0_latency", cyc, e.cyc);
               if (e.we) ref_mem[e.addr] = e.wdata;
            end
         end
         if (m1_rvalid) begin
            rv1_cnt++;
            if (sb1.size() == 0) check("m1_unexpected_rvalid", 1, 0);
            else begin
               e = sb1.pop_front();
               check("m1_rdata", m1_rdata, e.we ? 32'd0 : ref_mem[e.addr]);
               check("m1_latency", cyc, e.cyc);
               if (e.we) ref_mem[e.addr] = e.wdata;
            end
         end
      end
   end

   // Called at posedge+1; raises the request and returns at posedge+1 of the cycle after ready.
   task automatic issue(input logic p, input logic [3:0] a, input logic [31:0] d,
                        input logic w, output int waited);
      logic got;
      got = 1'b0;
      waited = 0;
      if (p) begin m1_req = 1'b1; m1_addr = {28'd0, a}; m1_wdata = d; m1_we = w; end
      else   begin m0_req = 1'b1; m0_addr = {28'd0, a}; m0_wdata = d; m0_we = w; end
      while (!got && waited < 30) begin
         @(negedge clk);
         waited++;
         got = p ? m1_ready : m0_ready;
      end
      if (!got) check(p ? "m1_ready_timeout" : "m0_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   int w0, w1, rv_before;

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]     = 32'hA000_0000 + i;
         ref_mem[i] = 32'hA000_0000 + i;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Write then read back the same word.
      issue(1'b0, 4'd3, 32'h0000_0007, 1'b1, w0); m0_req = 1'b0;
      issue(1'b0, 4'd3, 32'h0, 1'b0, w0);         m0_req = 1'b0;
      settle();
      check("wr_rd_mem3", mem[3], 32'h0000_0007);

      // Reset, then a tie: port 0 must win first.
      reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      acc_log.delete();
      fork
         begin issue(1'b0, 4'd1, 32'h0, 1'b0, w0); m0_req = 1'b0; end
         begin issue(1'b1, 4'd3, 32'h0, 1'b0, w1); m1_req = 1'b0; end
      join
      settle();
      check("tie_count", acc_log.size(), 2);
      if (acc_log.size() >= 2) begin
         check("tie_first", acc_log[0], 0);
         check("tie_second", acc_log[1], 1);
      end

      // m1 streams continuously; m0 must get in within one m1 transaction.
      fork
         begin
            for (int i = 0; i < 5; i++) issue(1'b1, 4'(8 + i), 32'h0, 1'b0, w1);
            m1_req = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            issue(1'b0, 4'd2, 32'h0, 1'b0, w0);
            m0_req = 1'b0;
            check("starve_bound", w0 <= 3, 1);
         end
      join
      settle();

      // Reset during ACCESS of an m1 write to addr 5.
      rv_before = rv1_cnt;
      issue(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, w1);
      m1_req = 1'b0;
      check("abort_we_before", ram_write_enable, 1);
      #2 reset = 1'b0;
      #1;
      check("abort_we", ram_write_enable, 0);
      check("abort_busy", busy, 0);
      check("abort_rvalid", m1_rvalid, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      settle();
      check("abort_no_rvalid", rv1_cnt, rv_before);
      check("abort_mem5", mem[5], ref_mem[5]);
      issue(1'b1, 4'd5, 32'h0, 1'b0, w1); m1_req = 1'b0;
      settle();

      // Idle window.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_we", ram_write_enable, 0);
         check("idle_hs", {m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 0);
      end
      @(posedge clk); #1;

      // Request dropped right after ready still completes once.
      rv_before = rv0_cnt;
      issue(1'b0, 4'd2, 32'h0, 1'b0, w0);
      m0_req = 1'b0;
      settle();
      check("drop_req_one_rvalid", rv0_cnt - rv_before, 1);

      // Random traffic from both ports.
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               issue(1'b0, 4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)), w0);
               m0_req = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               issue(1'b1, 4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)), w1);
               m1_req = 1'b0;
            end
         end
      join
      settle();

      check("sb0_drained", sb0.size(), 0);
      check("sb1_drained", sb1.size(), 0);
      for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
